// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one external memory port between the I-cache refill engine and the
// D-cache refill/writeback engine. Each grant runs a whole-line burst of BURST_LEN word beats.
// The arbiter sequences the beat addresses, forwards read data and pulses done at the end.
// D-cache has priority, but an I-cache request left waiting by one D-cache burst wins the
// next arbitration.
//
// Ports
//   clk_i, rst_i                  clock; synchronous active-high reset
//   ic_req_i, ic_addr_i           I-cache read-burst request and line address
//   ic_rvalid_o, ic_rdata_o       I-cache read beat
//   ic_done_o                     I-cache burst complete (one-cycle pulse)
//   dc_req_i, dc_we_i, dc_addr_i  D-cache burst request, direction and line address
//   dc_wdata_i, dc_beat_o         D-cache write data for the beat index on dc_beat_o
//   dc_rvalid_o, dc_rdata_o       D-cache read beat
//   dc_done_o                     D-cache burst complete (one-cycle pulse)
//   mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_ack_i, mem_rdata_i  memory beat port
module mem_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         ic_req_i,
  input  logic [ADDR_W-1:0]            ic_addr_i,
  output logic                         ic_rvalid_o,
  output logic [DATA_W-1:0]            ic_rdata_o,
  output logic                         ic_done_o,
  input  logic                         dc_req_i,
  input  logic                         dc_we_i,
  input  logic [ADDR_W-1:0]            dc_addr_i,
  input  logic [DATA_W-1:0]            dc_wdata_i,
  output logic [$clog2(BURST_LEN)-1:0] dc_beat_o,
  output logic                         dc_rvalid_o,
  output logic [DATA_W-1:0]            dc_rdata_o,
  output logic                         dc_done_o,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [ADDR_W-1:0]            mem_addr_o,
  output logic [DATA_W-1:0]            mem_wdata_o,
  input  logic                         mem_ack_i,
  input  logic [DATA_W-1:0]            mem_rdata_i
);

  localparam int unsigned BeatW = $clog2(BURST_LEN);
  localparam int unsigned OffW  = BeatW + 2;
  localparam int unsigned BaseW = ADDR_W - OffW;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(BURST_LEN - 1);

  typedef enum logic [1:0] {StIdle, StIcBurst, StDcBurst} state_e;

  state_e              state_q, state_d;
  logic [BeatW-1:0]    beat_q, beat_d;
  logic [BaseW-1:0]    base_q, base_d;
  logic                we_q, we_d;
  logic                starve_q, starve_d;
  logic                ic_rvalid_q, ic_rvalid_d;
  logic                dc_rvalid_q, dc_rvalid_d;
  logic                ic_done_q, ic_done_d;
  logic                dc_done_q, dc_done_d;
  logic [DATA_W-1:0]   ic_rdata_q, ic_rdata_d;
  logic [DATA_W-1:0]   dc_rdata_q, dc_rdata_d;

  logic ic_elig, dc_elig, in_burst;

  // Line offset bits of the request addresses are replaced by the beat counter.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ic_addr_i[OffW-1:0], dc_addr_i[OffW-1:0]};

  // A requester still holds req during its own done cycle; masking it there prevents an
  // immediate regrant of the burst that just finished.
  assign ic_elig  = ic_req_i & ~ic_done_q;
  assign dc_elig  = dc_req_i & ~dc_done_q;
  assign in_burst = (state_q != StIdle);

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    base_d      = base_q;
    we_d        = we_q;
    starve_d    = starve_q;
    ic_rvalid_d = 1'b0;
    dc_rvalid_d = 1'b0;
    ic_done_d   = 1'b0;
    dc_done_d   = 1'b0;
    ic_rdata_d  = ic_rdata_q;
    dc_rdata_d  = dc_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (dc_elig && (!ic_elig || !starve_q)) begin
          state_d = StDcBurst;
          beat_d  = '0;
          base_d  = dc_addr_i[ADDR_W-1:OffW];
          we_d    = dc_we_i;
        end else if (ic_elig) begin
          state_d  = StIcBurst;
          beat_d   = '0;
          base_d   = ic_addr_i[ADDR_W-1:OffW];
          we_d     = 1'b0;
          starve_d = 1'b0;
        end
      end
      StIcBurst, StDcBurst: begin
        if (mem_ack_i) begin
          beat_d = beat_q + BeatW'(1);
          if (!we_q) begin
            if (state_q == StIcBurst) begin
              ic_rvalid_d = 1'b1;
              ic_rdata_d  = mem_rdata_i;
            end else begin
              dc_rvalid_d = 1'b1;
              dc_rdata_d  = mem_rdata_i;
            end
          end
          if (beat_q == LastBeat) begin
            state_d = StIdle;
            if (state_q == StIcBurst) begin
              ic_done_d = 1'b1;
            end else begin
              dc_done_d = 1'b1;
              // I-cache waited through this whole D-cache burst: it wins next time.
              if (ic_req_i) begin
                starve_d = 1'b1;
              end
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      beat_q      <= '0;
      base_q      <= '0;
      we_q        <= 1'b0;
      starve_q    <= 1'b0;
      ic_rvalid_q <= 1'b0;
      dc_rvalid_q <= 1'b0;
      ic_done_q   <= 1'b0;
      dc_done_q   <= 1'b0;
      ic_rdata_q  <= '0;
      dc_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      base_q      <= base_d;
      we_q        <= we_d;
      starve_q    <= starve_d;
      ic_rvalid_q <= ic_rvalid_d;
      dc_rvalid_q <= dc_rvalid_d;
      ic_done_q   <= ic_done_d;
      dc_done_q   <= dc_done_d;
      ic_rdata_q  <= ic_rdata_d;
      dc_rdata_q  <= dc_rdata_d;
    end
  end

  assign mem_req_o   = in_burst;
  assign mem_we_o    = in_burst & we_q;
  assign mem_addr_o  = in_burst ? {base_q, beat_q, 2'b00} : '0;
  assign mem_wdata_o = dc_wdata_i;
  assign dc_beat_o   = beat_q;
  assign ic_rvalid_o = ic_rvalid_q;
  assign ic_rdata_o  = ic_rdata_q;
  assign ic_done_o   = ic_done_q;
  assign dc_rvalid_o = dc_rvalid_q;
  assign dc_rdata_o  = dc_rdata_q;
  assign dc_done_o   = dc_done_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single external memory port between the I-cache and D-cache line-refill/writeback engines. Each requester issues whole-line bursts of BURST_LEN word beats; the arbiter grants one requester at a time, sequences the beat addresses, forwards read data, and signals completion. D-cache has priority, but never more than one consecutive D-cache burst while an I-cache request waits. It sits between the two caches and the memory interface, underneath the pipeline stall controller.

## Interface
- ADDR_W, 32, byte-address width
- DATA_W, 32, word width
- BURST_LEN, 4, beats per burst; power of 2, ≥2
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- ic_req  in  1  I-cache burst request (read only), level, held until ic_done
- ic_addr  in  ADDR_W  I-cache line base address, stable while ic_req
- ic_rvalid  out  1  one beat of I-cache read data valid
- ic_rdata  out  DATA_W  read data for I-cache
- ic_done  out  1  one-cycle pulse, I-cache burst complete
- dc_req  in  1  D-cache burst request, level, held until dc_done
- dc_we  in  1  1 = writeback burst, 0 = refill; stable while dc_req
- dc_addr  in  ADDR_W  D-cache line base address, stable while dc_req
- dc_wdata  in  DATA_W  write data for beat dc_beat
- dc_beat  out  log2(BURST_LEN)  current beat index of D-cache burst
- dc_rvalid  out  1  one beat of D-cache read data valid
- dc_rdata  out  DATA_W  read data for D-cache
- dc_done  out  1  one-cycle pulse, D-cache burst complete
- mem_req  out  1  beat request to memory
- mem_we  out  1  beat is a write
- mem_addr  out  ADDR_W  beat byte address
- mem_wdata  out  DATA_W  beat write data (= dc_wdata, combinational)
- mem_ack  in  1  beat accepted/completed; read data valid on mem_rdata same cycle
- mem_rdata  in  DATA_W  memory read data

## Operation
- States: IDLE, IC_BURST, DC_BURST.
- Eligibility in IDLE: a requester is eligible if its req=1 and its own done output is 0 this cycle (masks the stale req in the done cycle).
- Grant in IDLE: only one eligible → grant it. Both eligible → D-cache, unless starve=1, then I-cache.
- starve flag: set when a DC burst completes while ic_req=1; cleared when an IC burst is granted; reset 0.
- On grant: beat counter ←0, capture base = req_addr with low log2(BURST_LEN)+2 bits zeroed, latch we (I-cache always 0); enter burst state.
- In burst state: mem_req=1; mem_addr = {base upper bits, beat, 2'b00}; mem_we = latched we. Beat index wraps only via burst end (no carry into upper address bits).
- mem_ack with mem_req=1: beat increments; if beat==BURST_LEN-1, go to IDLE next cycle (mem_req=0 in that cycle).
- Read beats: on ack, register mem_rdata into granted requester's rdata and pulse its rvalid next cycle. Write beats: no rvalid.
- done: pulsed the cycle after the final ack (coincides with last rvalid on reads); arbiter is in IDLE that cycle.
- mem_ack in IDLE ignored. ic_rdata/dc_rdata hold last captured value when rvalid=0.
- Reset (any time, incl. mid-burst): state IDLE, mem_req/mem_we 0, mem_addr 0, beat 0, starve 0, all rvalid/done 0, rdata 0. Abandoned burst is not resumed; memory model drops it.

## Timing
- Grant latency: req eligible in cycle N (IDLE) → mem_req=1 in N+1 with beat-0 address.
- Zero-wait memory (ack whenever mem_req): BURST_LEN cycles of mem_req, done at N+1+BURST_LEN; next grant can issue mem_req at N+2+BURST_LEN (one IDLE cycle between bursts).
- mem_addr/mem_we change only in the cycle after an ack or grant; stable while waiting for ack.
- dc_beat valid whenever state=DC_BURST; D-cache must present dc_wdata for dc_beat combinationally.
- Requesters drop req in the cycle after seeing done or later; arbiter guarantees no regrant in the done cycle.

## Test plan
- I-cache read, zero-wait, ic_addr=0x0000_1234: mem_addr 0x1230,0x1234,0x1238,0x123C on consecutive cycles; 4 ic_rvalid with returned data; ic_done with 4th rvalid; dc outputs idle.
- D-cache writeback, dc_addr=0x40, ack after 2 wait cycles per beat: mem_we=1, addr held 3 cycles per beat, mem_wdata follows dc_beat 0..3; no dc_rvalid; single dc_done.
- ic_req and dc_req rise same cycle: DC burst first; IC granted in IDLE cycle after dc_done; starve cleared.
- dc_req reasserted immediately after each dc_done with ic_req pending: order DC, IC, DC, IC — never two DC bursts back-to-back.
- rst asserted at beat 2 of IC read: next cycle all outputs 0, state IDLE; after rst drops with ic_req high, burst restarts at beat 0.
- mem_ack pulsed while IDLE and during done cycle: no rvalid, no state change, no extra beat.
